// File: rtl/match_health_ctrl_pkg.sv
// Shared definitions for the two-fighter match controller: phase encodings,
// parameter defaults and the round-winner decision.
package match_health_ctrl_pkg;

  localparam int PHASE_W = 2;

  localparam logic [PHASE_W-1:0] PH_IDLE       = 2'd0;
  localparam logic [PHASE_W-1:0] PH_FIGHT      = 2'd1;
  localparam logic [PHASE_W-1:0] PH_ROUND_END  = 2'd2;
  localparam logic [PHASE_W-1:0] PH_MATCH_OVER = 2'd3;

  localparam int DEF_HEALTH_W      = 3;
  localparam int DEF_MAX_HEALTH    = 5;
  localparam int DEF_ROUND_W       = 2;
  localparam int DEF_ROUNDS_TO_WIN = 2;
  localparam int DEF_INVULN_TICKS  = 8;
  localparam int DEF_TIMER_W       = 13;
  localparam int DEF_ROUND_TICKS   = 5400;
  localparam int DEF_PAUSE_TICKS   = 120;

  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_P1   = 2'd1,
    WIN_P2   = 2'd2
  } round_winner_t;

  // Higher remaining health takes the round; this covers a single KO (the
  // survivor is higher) as well as a timeout. Equal values, including a
  // double KO, are a draw.
  function automatic round_winner_t pick_winner(input int unsigned h1, input int unsigned h2);
    if (h1 > h2) return WIN_P1;
    if (h2 > h1) return WIN_P2;
    return WIN_NONE;
  endfunction

endpackage

// File: rtl/match_health_ctrl_if.sv
// Bundle between hit logic / fsm / renderer and the match controller.
// master drives the game-frame inputs, slave is the controller itself.
interface match_health_ctrl_if
  import match_health_ctrl_pkg::*;
#(
  parameter int HEALTH_W = DEF_HEALTH_W,
  parameter int ROUND_W  = DEF_ROUND_W,
  parameter int TIMER_W  = DEF_TIMER_W
);

  logic                tick;
  logic                start;
  logic                hit1_lands;
  logic                hit2_lands;
  logic [HEALTH_W-1:0] health1;
  logic [HEALTH_W-1:0] health2;
  logic [ROUND_W-1:0]  rounds1;
  logic [ROUND_W-1:0]  rounds2;
  logic [TIMER_W-1:0]  timer;
  logic                invuln1;
  logic                invuln2;
  logic                round_reset;
  logic [PHASE_W-1:0]  phase;
  logic                game_over1;
  logic                game_over2;

  modport master (
    output tick, start, hit1_lands, hit2_lands,
    input  health1, health2, rounds1, rounds2, timer, invuln1, invuln2,
           round_reset, phase, game_over1, game_over2
  );

  modport slave (
    input  tick, start, hit1_lands, hit2_lands,
    output health1, health2, rounds1, rounds2, timer, invuln1, invuln2,
           round_reset, phase, game_over1, game_over2
  );

endinterface

// File: rtl/match_health_ctrl_fighter_health.sv
// One fighter's health and post-hit invulnerability. Exposes the value the
// health register takes on this clock so the round decision sees the same tick.
module fighter_health
  import match_health_ctrl_pkg::*;
#(
  parameter int HEALTH_W     = DEF_HEALTH_W,
  parameter int MAX_HEALTH   = DEF_MAX_HEALTH,
  parameter int INVULN_TICKS = DEF_INVULN_TICKS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                reload,
  input  logic                hit_in,
  input  logic                freeze,
  output logic [HEALTH_W-1:0] health,
  output logic [HEALTH_W-1:0] health_next,
  output logic                invuln,
  output logic                ko
);

  localparam int INV_W = $clog2(INVULN_TICKS + 1);
  localparam logic [HEALTH_W-1:0] HEALTH_LOAD = HEALTH_W'(MAX_HEALTH);
  localparam logic [INV_W-1:0]    INV_LOAD    = INV_W'(INVULN_TICKS);

  logic [INV_W-1:0] inv_cnt;
  logic [INV_W-1:0] inv_next;

  // A hit only counts while the counter is already zero, so the tick on which
  // it counts down to zero still ignores hits.
  always_comb begin
    health_next = health;
    inv_next    = inv_cnt;
    if (tick) begin
      if (reload) begin
        health_next = HEALTH_LOAD;
        inv_next    = '0;
      end else if (hit_in && !freeze && (inv_cnt == '0)) begin
        health_next = (health == '0) ? '0 : health - 1'b1;
        inv_next    = INV_LOAD;
      end else if (inv_cnt != '0) begin
        inv_next = inv_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      health  <= HEALTH_LOAD;
      inv_cnt <= '0;
    end else begin
      health  <= health_next;
      inv_cnt <= inv_next;
    end
  end

  assign invuln = (inv_cnt != '0);
  assign ko     = (health_next == '0);

endmodule

// File: rtl/match_health_ctrl.sv
// Match controller: phase FSM, round timer, post-round pause and round wins
// for two fighters, advancing only on the game tick.
module match_health_ctrl
  import match_health_ctrl_pkg::*;
#(
  parameter int HEALTH_W      = DEF_HEALTH_W,
  parameter int MAX_HEALTH    = DEF_MAX_HEALTH,
  parameter int ROUND_W       = DEF_ROUND_W,
  parameter int ROUNDS_TO_WIN = DEF_ROUNDS_TO_WIN,
  parameter int INVULN_TICKS  = DEF_INVULN_TICKS,
  parameter int TIMER_W       = DEF_TIMER_W,
  parameter int ROUND_TICKS   = DEF_ROUND_TICKS,
  parameter int PAUSE_TICKS   = DEF_PAUSE_TICKS
) (
  input logic               clk,
  input logic               reset,
  match_health_ctrl_if.slave bus
);

  localparam int PAUSE_W = $clog2(PAUSE_TICKS + 1);
  localparam logic [TIMER_W-1:0] ROUND_LOAD  = TIMER_W'(ROUND_TICKS);
  localparam logic [ROUND_W-1:0] ROUNDS_GOAL = ROUND_W'(ROUNDS_TO_WIN);
  localparam logic [PAUSE_W-1:0] PAUSE_LOAD  = PAUSE_W'(PAUSE_TICKS - 1);

  logic [PHASE_W-1:0]  phase;
  logic [TIMER_W-1:0]  timer;
  logic [TIMER_W-1:0]  timer_dec;
  logic [PAUSE_W-1:0]  pause_cnt;
  logic [ROUND_W-1:0]  rounds1;
  logic [ROUND_W-1:0]  rounds2;
  logic                round_reset;
  logic                start_round;
  logic                reload;
  logic                freeze;
  logic                match_won;
  logic                round_over;
  logic [HEALTH_W-1:0] health1;
  logic [HEALTH_W-1:0] health2;
  logic [HEALTH_W-1:0] health1_next;
  logic [HEALTH_W-1:0] health2_next;
  logic                invuln1;
  logic                invuln2;
  logic                ko1;
  logic                ko2;
  round_winner_t       winner;

  assign freeze    = (phase != PH_FIGHT);
  assign match_won = (rounds1 == ROUNDS_GOAL) || (rounds2 == ROUNDS_GOAL);

  // Any transition into FIGHT reloads both fighters on the same tick.
  always_comb begin
    start_round = 1'b0;
    case (phase)
      PH_IDLE, PH_MATCH_OVER: start_round = bus.start;
      PH_ROUND_END:           start_round = (pause_cnt == '0) && !match_won;
      default:                start_round = 1'b0;
    endcase
  end

  assign reload = bus.tick && start_round;

  // Player 1 loses health when player 2's hit lands, and vice versa.
  fighter_health #(
    .HEALTH_W    (HEALTH_W),
    .MAX_HEALTH  (MAX_HEALTH),
    .INVULN_TICKS(INVULN_TICKS)
  ) u_fighter1 (
    .clk        (clk),
    .reset      (reset),
    .tick       (bus.tick),
    .reload     (reload),
    .hit_in     (bus.hit2_lands),
    .freeze     (freeze),
    .health     (health1),
    .health_next(health1_next),
    .invuln     (invuln1),
    .ko         (ko1)
  );

  fighter_health #(
    .HEALTH_W    (HEALTH_W),
    .MAX_HEALTH  (MAX_HEALTH),
    .INVULN_TICKS(INVULN_TICKS)
  ) u_fighter2 (
    .clk        (clk),
    .reset      (reset),
    .tick       (bus.tick),
    .reload     (reload),
    .hit_in     (bus.hit1_lands),
    .freeze     (freeze),
    .health     (health2),
    .health_next(health2_next),
    .invuln     (invuln2),
    .ko         (ko2)
  );

  assign timer_dec  = (timer == '0) ? '0 : timer - 1'b1;
  assign round_over = ko1 || ko2 || (timer_dec == '0);
  assign winner     = pick_winner(32'(health1_next), 32'(health2_next));

  // round_reset is a one-clock pulse: cleared every clock, set only on the
  // tick that opens a round.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase       <= PH_IDLE;
      timer       <= ROUND_LOAD;
      pause_cnt   <= '0;
      rounds1     <= '0;
      rounds2     <= '0;
      round_reset <= 1'b0;
    end else begin
      round_reset <= 1'b0;
      if (bus.tick) begin
        case (phase)
          PH_IDLE: begin
            if (bus.start) begin
              phase       <= PH_FIGHT;
              timer       <= ROUND_LOAD;
              round_reset <= 1'b1;
            end
          end
          PH_FIGHT: begin
            timer <= timer_dec;
            if (round_over) begin
              phase     <= PH_ROUND_END;
              pause_cnt <= PAUSE_LOAD;
              if (winner == WIN_P1) rounds1 <= rounds1 + 1'b1;
              if (winner == WIN_P2) rounds2 <= rounds2 + 1'b1;
            end
          end
          PH_ROUND_END: begin
            if (pause_cnt != '0) begin
              pause_cnt <= pause_cnt - 1'b1;
            end else if (match_won) begin
              phase <= PH_MATCH_OVER;
            end else begin
              phase       <= PH_FIGHT;
              timer       <= ROUND_LOAD;
              round_reset <= 1'b1;
            end
          end
          PH_MATCH_OVER: begin
            if (bus.start) begin
              phase       <= PH_FIGHT;
              timer       <= ROUND_LOAD;
              rounds1     <= '0;
              rounds2     <= '0;
              round_reset <= 1'b1;
            end
          end
          default: phase <= PH_IDLE;
        endcase
      end
    end
  end

  assign bus.health1     = health1;
  assign bus.health2     = health2;
  assign bus.rounds1     = rounds1;
  assign bus.rounds2     = rounds2;
  assign bus.timer       = timer;
  assign bus.invuln1     = invuln1;
  assign bus.invuln2     = invuln2;
  assign bus.round_reset = round_reset;
  assign bus.phase       = phase;
  assign bus.game_over1  = (phase == PH_MATCH_OVER) && (rounds2 == ROUNDS_GOAL);
  assign bus.game_over2  = (phase == PH_MATCH_OVER) && (rounds1 == ROUNDS_GOAL);

endmodule
